hms_cnt: RTL

//  Time-keeping core of the digital watch: holds hours/minutes/seconds and advances them once per second.

---
 rtl/watch_pkg.sv | 18 +
 rtl/mod_n_cnt.sv | 29 ++
 rtl/hms_cnt.sv | 87 ++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared watch definitions: controller mode/position encodings and time field widths.
package watch_pkg;

  localparam logic [1:0] MODE_CLOCK = 2'b00;
  localparam logic [1:0] MODE_SETUP = 2'b01;
  localparam logic [1:0] MODE_ALARM = 2'b10;
  localparam logic [1:0] MODE_TIMER = 2'b11;

  localparam logic [1:0] POS_SEC  = 2'b00;
  localparam logic [1:0] POS_MIN  = 2'b01;
  localparam logic [1:0] POS_HOU  = 2'b10;
  localparam logic [1:0] POS_NONE = 2'b11;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/mod_n_cnt.sv
// Enabled modulo-N counter with a combinational carry out for chaining.
module mod_n_cnt #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_no_carry,
  output logic [W-1:0] o_cnt,
  output logic         o_carry
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Wrapping on >= keeps any out-of-range value from surviving an increment.
  logic at_last;
  assign at_last = (o_cnt >= LAST);
  assign o_carry = i_en & ~i_no_carry & at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= at_last ? '0 : o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/hms_cnt.sv
// Watch time-keeping core: 1 Hz enable divider plus a chained sec/min/hour counter,
// with direct per-field increments while in SETUP.
module hms_cnt
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int HOUR_MAX = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_position,
  input  logic              i_incr,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  localparam int              TW        = $clog2(CLK_HZ);
  localparam logic [TW-1:0]   TICK_LAST = TW'(CLK_HZ - 1);

  logic [TW-1:0] tick_cnt;
  logic          setup;
  logic          wrap;

  assign setup = (i_mode == MODE_SETUP);
  assign wrap  = ~setup & (tick_cnt == TICK_LAST);

  // Held at zero in SETUP so the first tick after leaving it is a full second away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      o_tick   <= 1'b0;
    end else begin
      o_tick <= wrap;
      if (setup || wrap) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  logic sec_en, min_en, hour_en;
  logic sec_carry, min_carry, hour_carry_unused;

  always_comb begin
    if (setup) begin
      sec_en  = i_incr & (i_position == POS_SEC);
      min_en  = i_incr & (i_position == POS_MIN);
      hour_en = i_incr & (i_position == POS_HOU);
    end else begin
      sec_en  = wrap;
      min_en  = sec_carry;
      hour_en = min_carry;
    end
  end

  mod_n_cnt #(.N(60), .W(SEC_W)) u_sec (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (sec_en),
    .i_no_carry (setup),
    .o_cnt      (o_sec),
    .o_carry    (sec_carry)
  );

  mod_n_cnt #(.N(60), .W(MIN_W)) u_min (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (min_en),
    .i_no_carry (setup),
    .o_cnt      (o_min),
    .o_carry    (min_carry)
  );

  mod_n_cnt #(.N(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (hour_en),
    .i_no_carry (setup),
    .o_cnt      (o_hour),
    .o_carry    (hour_carry_unused)
  );

endmodule
